// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   INST_NOP          : word presented on inst_o when no instruction is valid
//   RESET_PC_DEFAULT  : default first fetch address
//   ifu_state_e       : fetch FSM states (IDLE/REQ/WAIT/DROP)
//   fetch_entry_t     : {address, instruction} pair held in the fetch buffer
package ifu_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_DROP = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{addr: 32'h0000_0000, inst: INST_NOP};

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of {addr, inst} pairs with a
// registered head. When empty the head reads as {0, INST_NOP}.
//   clk, rst      : clock, async active-high reset
//   clear_i       : drop all entries (takes priority over push/pop)
//   push_i        : write push_data_i this cycle
//   push_data_i   : entry to write
//   pop_i         : consumer takes the head this cycle
//   valid_o       : head holds a real entry
//   head_o        : head entry
//   count_o       : entries currently held
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [CW-1:0] count_q, count_d, cnt_after_pop;
  fetch_entry_t  head_q, head_d;
  logic          valid_q;
  logic          pop;

  assign pop = pop_i && (count_q != '0);

  // Next head: the pushed word bypasses storage only when nothing else remains.
  always_comb begin
    cnt_after_pop = count_q - CW'(pop);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    count_d       = cnt_after_pop + CW'(push_i);
    head_d        = EMPTY_ENTRY;
    if (count_d != '0) begin
      if (cnt_after_pop == '0) head_d = push_data_i;
      else                     head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= EMPTY_ENTRY;
      valid_q  <= 1'b0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= EMPTY_ENTRY;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  // Storage needs no reset; only entries below count_q are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Generates the PC, fetches one word at a time over
// a req/gnt/rvalid memory handshake, buffers responses and presents
// {inst_addr, inst} to the if_id register. Jumps redirect the PC, flush the
// buffer and discard any response still in flight.
//   clk, rst               : clock, async active-high reset
//   jump_en_i/jump_addr_i  : redirect pulse and target from execute
//   imem_req_o/imem_addr_o : fetch request and word address
//   imem_gnt_i             : request accepted
//   imem_rvalid_i/rdata_i  : read response (in order, >=1 cycle after gnt)
//   inst_valid_o/ready_i   : head handshake with if_id
//   inst_addr_o/inst_o     : head address and instruction (0/NOP if empty)
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e    state_q;
  logic [31:0]   pc_q;
  logic [31:0]   fetch_addr_q;
  logic          req_q;
  logic [31:0]   jump_tgt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] cnt_after_pop;
  logic          pop, push;
  logic          has_space, space_after_push;
  fetch_entry_t  push_data, head;

  assign jump_tgt         = word_align(jump_addr_i);
  assign pop              = inst_valid_o && inst_ready_i;
  assign cnt_after_pop    = fifo_count - CW'(pop);
  assign has_space        = cnt_after_pop < CW'(FIFO_DEPTH);
  assign space_after_push = (cnt_after_pop + CW'(1)) < CW'(FIFO_DEPTH);
  // A response coinciding with a jump belongs to the old stream.
  assign push             = (state_q == IFU_WAIT) && imem_rvalid_i && !jump_en_i;
  assign push_data        = '{addr: fetch_addr_q, inst: imem_rdata_i};

  // Fetch FSM and PC. A request is only launched with a free buffer slot
  // reserved, so the response can always be pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
      req_q        <= 1'b0;
    end else if (jump_en_i) begin
      pc_q <= jump_tgt;
      case (state_q)
        IFU_REQ: begin
          // Granted old-address request still owes a response.
          state_q <= imem_gnt_i ? IFU_DROP : IFU_REQ;
          req_q   <= !imem_gnt_i;
        end
        IFU_WAIT, IFU_DROP: begin
          state_q <= imem_rvalid_i ? IFU_REQ : IFU_DROP;
          req_q   <= imem_rvalid_i;
        end
        default: begin
          state_q <= IFU_REQ;
          req_q   <= 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        IFU_IDLE: begin
          if (has_space) begin
            state_q <= IFU_REQ;
            req_q   <= 1'b1;
          end
        end
        IFU_REQ: begin
          if (imem_gnt_i) begin
            state_q      <= IFU_WAIT;
            req_q        <= 1'b0;
            fetch_addr_q <= pc_q;
            pc_q         <= pc_q + 32'd4;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= space_after_push ? IFU_REQ : IFU_IDLE;
            req_q   <= space_after_push;
          end
        end
        IFU_DROP: begin
          if (imem_rvalid_i) begin
            state_q <= IFU_REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IFU_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  ifu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (jump_en_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .valid_o     (inst_valid_o),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign inst_addr_o = head.addr;
  assign inst_o      = head.inst;

endmodule
